// File: rtl/wb_stage_gen.sv
// Writeback stage: accepts one MEM instruction per cycle, drives RF write, trace and CSR exception info.
// Flushes (exception or ertn) open a FLUSH_DROP-cycle window that discards MEM arrivals.
module wb_stage_gen #(
  parameter int DATA_W     = 32,
  parameter int RF_AW      = 5,
  parameter int CNT_W      = 32,
  parameter int FLUSH_DROP = 1,
  parameter int DBG_WE_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ms_to_ws_valid,
  output logic                ws_allowin,
  input  logic [DATA_W-1:0]   ms_pc,
  input  logic                ms_rf_we,
  input  logic [RF_AW-1:0]    ms_rf_waddr,
  input  logic [DATA_W-1:0]   ms_rf_wdata,
  input  logic [9:0]          ms_exc,
  input  logic                ms_exc_if,
  input  logic                ms_ertn,
  input  logic [DATA_W-1:0]   ms_vaddr,
  input  logic                ws_hold,
  output logic                ws_rf_we,
  output logic [RF_AW-1:0]    ws_rf_waddr,
  output logic [DATA_W-1:0]   ws_rf_wdata,
  output logic                wb_ex,
  output logic                ertn_flush,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic [DATA_W-1:0]   wb_pc,
  output logic [DATA_W-1:0]   wb_vaddr,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [DATA_W-1:0]   debug_wb_pc,
  output logic [DBG_WE_W-1:0] debug_wb_rf_we,
  output logic [RF_AW-1:0]    debug_wb_rf_wnum,
  output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

  logic              ws_valid;
  logic [DATA_W-1:0] pc_q;
  logic              rf_we_q;
  logic [RF_AW-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [9:0]        exc_q;
  logic              exc_if_q;
  logic              ertn_q;
  logic [DATA_W-1:0] vaddr_q;
  logic [3:0]        drop_cnt;

  logic ready_go, drop_active, commit, has_exc, flush, accept;

  assign ready_go    = ~ws_hold;
  assign drop_active = (drop_cnt != 4'd0);
  assign ws_allowin  = ~ws_valid | (ready_go & ~drop_active);
  assign commit      = ws_valid & ready_go;
  assign has_exc     = |exc_q;
  assign wb_ex       = commit & has_exc;
  assign ertn_flush  = commit & ertn_q & ~has_exc;
  assign flush       = wb_ex | ertn_flush;
  // Arrivals during the flush cycle or the drop window are swallowed.
  assign accept      = ms_to_ws_valid & ws_allowin & ~drop_active & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid   <= 1'b0;
      pc_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      exc_q      <= '0;
      exc_if_q   <= 1'b0;
      ertn_q     <= 1'b0;
      vaddr_q    <= '0;
      drop_cnt   <= 4'd0;
      retire_cnt <= '0;
    end else begin
      if (flush)       ws_valid <= 1'b0;
      else if (accept) ws_valid <= 1'b1;
      else if (commit) ws_valid <= 1'b0;

      if (accept) begin
        pc_q       <= ms_pc;
        rf_we_q    <= ms_rf_we;
        rf_waddr_q <= ms_rf_waddr;
        rf_wdata_q <= ms_rf_wdata;
        exc_q      <= ms_exc;
        exc_if_q   <= ms_exc_if;
        ertn_q     <= ms_ertn;
        vaddr_q    <= ms_vaddr;
      end

      if (flush)            drop_cnt <= 4'(FLUSH_DROP);
      else if (drop_active) drop_cnt <= drop_cnt - 4'd1;

      if (commit & ~has_exc) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Lowest exception index has highest priority.
  always_comb begin
    wb_ecode    = 6'h00;
    wb_esubcode = 9'd0;
    if      (exc_q[0]) wb_ecode = 6'h00;
    else if (exc_q[1]) wb_ecode = 6'h08;
    else if (exc_q[2]) wb_ecode = 6'h3F;
    else if (exc_q[3]) wb_ecode = 6'h03;
    else if (exc_q[4]) wb_ecode = 6'h07;
    else if (exc_q[5]) wb_ecode = 6'h0B;
    else if (exc_q[6]) wb_ecode = 6'h0C;
    else if (exc_q[7]) wb_ecode = 6'h0D;
    else if (exc_q[8]) wb_ecode = 6'h09;
    else if (exc_q[9]) begin
      wb_ecode    = 6'h08;
      wb_esubcode = 9'd1;
    end
  end

  assign wb_pc             = pc_q;
  assign wb_vaddr          = exc_if_q ? pc_q : vaddr_q;
  assign ws_rf_we          = commit & rf_we_q & ~has_exc;
  assign ws_rf_waddr       = rf_waddr_q;
  assign ws_rf_wdata       = rf_wdata_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {DBG_WE_W{ws_rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage_gen.sv
// Directed bench for wb_stage_gen with FLUSH_DROP=2: per-cycle vector table plus an async reset sequence.
module tb_wb_stage_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ms_to_ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ms_pc = '0;
  logic        ms_rf_we = 1'b0;
  logic [4:0]  ms_rf_waddr = '0;
  logic [31:0] ms_rf_wdata = '0;
  logic [9:0]  ms_exc = '0;
  logic        ms_exc_if = 1'b0;
  logic        ms_ertn = 1'b0;
  logic [31:0] ms_vaddr = '0;
  logic        ws_hold = 1'b0;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic [31:0] ws_rf_wdata;
  logic        wb_ex, ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, retire_cnt, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  int checks = 0;
  int errors = 0;

  wb_stage_gen #(.DATA_W(32), .RF_AW(5), .CNT_W(32), .FLUSH_DROP(2), .DBG_WE_W(4)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_exc(ms_exc), .ms_exc_if(ms_exc_if), .ms_ertn(ms_ertn), .ms_vaddr(ms_vaddr),
    .ws_hold(ws_hold), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, hold, we, exc_if, ertn;
    logic [31:0] pc, wd, vaddr;
    logic [4:0]  rd;
    logic [9:0]  exc;
    logic        e_allow, e_we, e_ex, e_ertn, pchk;
    logic [31:0] e_ret, e_wdata, e_pc, e_vaddr;
    logic [4:0]  e_wnum;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
  } vec_t;

  function automatic vec_t mk(
    input logic v, hold, input logic [31:0] pc, input logic we, input logic [4:0] rd,
    input logic [31:0] wd, input logic [9:0] exc, input logic exc_if, ertn, input logic [31:0] vaddr,
    input logic e_allow, e_we, e_ex, e_ertn, input logic [31:0] e_ret, input logic pchk,
    input logic [4:0] e_wnum, input logic [31:0] e_wdata, e_pc, input logic [5:0] e_ecode,
    input logic [8:0] e_esub, input logic [31:0] e_vaddr);
    vec_t r;
    r.v = v; r.hold = hold; r.pc = pc; r.we = we; r.rd = rd; r.wd = wd; r.exc = exc;
    r.exc_if = exc_if; r.ertn = ertn; r.vaddr = vaddr;
    r.e_allow = e_allow; r.e_we = e_we; r.e_ex = e_ex; r.e_ertn = e_ertn; r.e_ret = e_ret;
    r.pchk = pchk; r.e_wnum = e_wnum; r.e_wdata = e_wdata; r.e_pc = e_pc;
    r.e_ecode = e_ecode; r.e_esub = e_esub; r.e_vaddr = e_vaddr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, hold, input logic [31:0] pc, input logic we,
                       input logic [4:0] rd, input logic [31:0] wd, input logic [9:0] exc,
                       input logic exc_if, ertn, input logic [31:0] vaddr);
    ms_to_ws_valid = v; ws_hold = hold; ms_pc = pc; ms_rf_we = we; ms_rf_waddr = rd;
    ms_rf_wdata = wd; ms_exc = exc; ms_exc_if = exc_if; ms_ertn = ertn; ms_vaddr = vaddr;
  endtask

  vec_t vecs[27];

  initial begin
    //            v  h  pc            we rd  wd     exc     if er vaddr          | al we ex er ret  pc? wnum wdata  pc            ecode esub vaddr
    vecs[0]  = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 0,   1,  0,   32'h0,  32'h0,        6'h00, 0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h1c000000, 1, 1,  32'h11, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 0,   0,  0,   0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h1c000004, 1, 2,  32'h22, 10'h000, 0, 0, 32'h0,         1, 1, 0, 0, 0,   1,  1,   32'h11, 32'h1c000000, 6'h00, 0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h1c000008, 1, 3,  32'h33, 10'h000, 0, 0, 32'h0,         1, 1, 0, 0, 1,   1,  2,   32'h22, 32'h1c000004, 6'h00, 0, 32'h0);
    vecs[4]  = mk(1, 1, 32'h1c00000c, 1, 4,  32'h44, 10'h000, 0, 0, 32'h0,         0, 0, 0, 0, 2,   1,  3,   32'h33, 32'h1c000008, 6'h00, 0, 32'h0);
    vecs[5]  = mk(1, 1, 32'h1c00000c, 1, 4,  32'h44, 10'h000, 0, 0, 32'h0,         0, 0, 0, 0, 2,   1,  3,   32'h33, 32'h1c000008, 6'h00, 0, 32'h0);
    vecs[6]  = mk(1, 0, 32'h1c00000c, 1, 4,  32'h44, 10'h000, 0, 0, 32'h0,         1, 1, 0, 0, 2,   1,  3,   32'h33, 32'h1c000008, 6'h00, 0, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 1, 0, 0, 3,   1,  4,   32'h44, 32'h1c00000c, 6'h00, 0, 32'h0);
    vecs[8]  = mk(1, 0, 32'h1c000010, 1, 5,  32'h55, 10'h120, 0, 0, 32'h1003,      1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 1, 0, 4,   1,  5,   32'h55, 32'h1c000010, 6'h0B, 0, 32'h1003);
    vecs[10] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 32'h1c000014, 1, 6,  32'h66, 10'h200, 0, 0, 32'h2004,      1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 32'h1c000018, 1, 8,  32'h88, 10'h000, 0, 0, 32'h0,         1, 0, 1, 0, 4,   1,  6,   32'h66, 32'h1c000014, 6'h08, 1, 32'h2004);
    vecs[14] = mk(1, 0, 32'h1c00001c, 1, 9,  32'h99, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 32'h1c000020, 1, 10, 32'haa, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 32'h1c000002, 1, 7,  32'h77, 10'h002, 1, 0, 32'hdead0000,  1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 1, 0, 4,   1,  7,   32'h77, 32'h1c000002, 6'h08, 0, 32'h1c000002);
    vecs[18] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 32'h1c000020, 1, 11, 32'hbb, 10'h000, 0, 1, 32'h0,         1, 0, 0, 0, 4,   0,  0,   0, 0, 0, 0, 0);
    vecs[21] = mk(1, 0, 32'h1c000024, 1, 12, 32'hcc, 10'h000, 0, 0, 32'h0,         1, 1, 0, 1, 4,   1,  11,  32'hbb, 32'h1c000020, 6'h00, 0, 32'h0);
    vecs[22] = mk(1, 0, 32'h1c000028, 1, 13, 32'hdd, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 5,   0,  0,   0, 0, 0, 0, 0);
    vecs[23] = mk(1, 0, 32'h1c00002c, 1, 14, 32'hee, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 5,   0,  0,   0, 0, 0, 0, 0);
    vecs[24] = mk(1, 0, 32'h1c000030, 1, 15, 32'hff, 10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 5,   0,  0,   0, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 1, 0, 0, 5,   1,  15,  32'hff, 32'h1c000030, 6'h00, 0, 32'h0);
    vecs[26] = mk(0, 0, 32'h0,        0, 0,  32'h0,  10'h000, 0, 0, 32'h0,         1, 0, 0, 0, 6,   0,  0,   0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].v, vecs[i].hold, vecs[i].pc, vecs[i].we, vecs[i].rd, vecs[i].wd,
            vecs[i].exc, vecs[i].exc_if, vecs[i].ertn, vecs[i].vaddr);
      #1;
      chk($sformatf("v%0d ws_allowin", i), 32'(ws_allowin), 32'(vecs[i].e_allow));
      chk($sformatf("v%0d ws_rf_we", i), 32'(ws_rf_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d debug_wb_rf_we", i), 32'(debug_wb_rf_we), 32'({4{vecs[i].e_we}}));
      chk($sformatf("v%0d wb_ex", i), 32'(wb_ex), 32'(vecs[i].e_ex));
      chk($sformatf("v%0d ertn_flush", i), 32'(ertn_flush), 32'(vecs[i].e_ertn));
      chk($sformatf("v%0d retire_cnt", i), retire_cnt, vecs[i].e_ret);
      if (vecs[i].pchk) begin
        chk($sformatf("v%0d ws_rf_waddr", i), 32'(ws_rf_waddr), 32'(vecs[i].e_wnum));
        chk($sformatf("v%0d debug_wb_rf_wnum", i), 32'(debug_wb_rf_wnum), 32'(vecs[i].e_wnum));
        chk($sformatf("v%0d ws_rf_wdata", i), ws_rf_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d debug_wb_rf_wdata", i), debug_wb_rf_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d debug_wb_pc", i), debug_wb_pc, vecs[i].e_pc);
        chk($sformatf("v%0d wb_pc", i), wb_pc, vecs[i].e_pc);
        chk($sformatf("v%0d wb_ecode", i), 32'(wb_ecode), 32'(vecs[i].e_ecode));
        chk($sformatf("v%0d wb_esubcode", i), 32'(wb_esubcode), 32'(vecs[i].e_esub));
        chk($sformatf("v%0d wb_vaddr", i), wb_vaddr, vecs[i].e_vaddr);
      end
    end

    // INE instruction held in WB, then async reset on the release cycle
    @(negedge clk);
    drive(1, 0, 32'h1c000040, 1, 1, 32'h12, 10'h080, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 1, 32'h0, 0, 0, 32'h0, 10'h000, 0, 0, 32'h0);
    #1;
    chk("hold allowin", 32'(ws_allowin), 32'd0);
    chk("hold wb_ex", 32'(wb_ex), 32'd0);
    @(negedge clk);
    chk("hold2 wb_ex", 32'(wb_ex), 32'd0);
    ws_hold = 1'b0;
    #1;
    chk("release wb_ex", 32'(wb_ex), 32'd1);
    chk("release ecode", 32'(wb_ecode), 32'h0D);
    chk("release rf_we", 32'(ws_rf_we), 32'd0);
    chk("release retire", retire_cnt, 32'd6);
    #1;
    reset = 1'b1;
    #1;
    chk("rst wb_ex", 32'(wb_ex), 32'd0);
    chk("rst ws_rf_we", 32'(ws_rf_we), 32'd0);
    chk("rst retire_cnt", retire_cnt, 32'd0);
    chk("rst ecode", 32'(wb_ecode), 32'd0);
    chk("rst debug_wb_pc", debug_wb_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-rst allowin", 32'(ws_allowin), 32'd1);
    chk("post-rst retire", retire_cnt, 32'd0);

    @(negedge clk);
    drive(1, 0, 32'h1c000050, 1, 2, 32'h5a, 10'h000, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 10'h000, 0, 0, 32'h0);
    #1;
    chk("post-rst write we", 32'(ws_rf_we), 32'd1);
    chk("post-rst write data", ws_rf_wdata, 32'h5a);
    @(negedge clk);
    #1;
    chk("post-rst retire 1", retire_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
